// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory handshake between the fetch unit and instruction memory.
//
//   imem_req    fetch unit -> memory   request a word at imem_addr this cycle
//   imem_addr   fetch unit -> memory   byte address of the requested word
//   imem_ready  memory -> fetch unit   the word on imem_data is valid now
//   imem_data   memory -> fetch unit   16-bit instruction word
//
// The fetch unit is the master; the instruction memory is the slave.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, talks to instruction memory through a
// req/ready handshake and fills the IF/ID pipeline register.
//
// Ports
//   clk                     single clock, all state on its rising edge
//   reset                   synchronous, active-low
//   pc_op, b_jmp            redirect request for the instruction in ID
//                           (b_jmp=1 branch, b_jmp=0 jump)
//   if_flush                replace the IF/ID word with a bubble
//   halt                    enter the sticky HALTED state
//   overflow_error_warning  enter the sticky ERROR state
//   stall                   hazard stall, freezes fetch
//   id_pc                   PC of the instruction in ID
//   branch_offset           signed byte offset for a taken branch
//   jump_field              12-bit jump target field
//   imem                    instruction-memory handshake (master side)
//   if_instr, if_pc,
//   if_valid                IF/ID register
//   halted, error           status (decoded from state)
//   state                   FETCH=00 WAIT=01 HALTED=10 ERROR=11
//   fetch_count             saturating count of accepted fetches
//
// Per-cycle priority: reset > overflow_error_warning > halt > redirect >
// stall > normal fetch. HALTED and ERROR only leave on reset.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'hF000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_op,
  input  logic                b_jmp,
  input  logic                if_flush,
  input  logic                halt,
  input  logic                overflow_error_warning,
  input  logic                stall,
  input  logic [15:0]         id_pc,
  input  logic [15:0]         branch_offset,
  input  logic [11:0]         jump_field,
  fetch_unit_if.master        imem,
  output logic [15:0]         if_instr,
  output logic [15:0]         if_pc,
  output logic                if_valid,
  output logic                halted,
  output logic                error,
  output logic [1:0]          state,
  output logic [15:0]         fetch_count
);

  localparam logic [1:0] ST_FETCH  = 2'b00;
  localparam logic [1:0] ST_WAIT   = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam logic [1:0] ST_ERROR  = 2'b11;

  // Branch target is id_pc + offset (wraps naturally in 16 bits); jump target
  // keeps the top three bits of id_pc and forms a halfword-aligned address.
  function automatic logic [15:0] redirect_target(
    input logic        is_branch,
    input logic [15:0] base_pc,
    input logic [15:0] offset,
    input logic [11:0] field
  );
    logic [15:0] target;
    if (is_branch) begin
      target = base_pc + offset;
    end else begin
      target = {base_pc[15:13], field, 1'b0};
    end
    return target;
  endfunction

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = 16'hFFFF;
    end else begin
      result = value + 16'h0001;
    end
    return result;
  endfunction

  logic [15:0] pc_r;
  logic [1:0]  state_r;
  logic [15:0] if_instr_r;
  logic [15:0] if_pc_r;
  logic        if_valid_r;
  logic [15:0] fetch_count_r;

  logic [15:0] pc_s;
  logic [1:0]  state_s;
  logic [15:0] if_instr_s;
  logic [15:0] if_pc_s;
  logic        if_valid_s;
  logic [15:0] fetch_count_s;

  logic        active_s;
  logic        imem_req_s;

  // Request decode: only FETCH/WAIT fetch, and any higher-priority event
  // (including reset) withdraws the request in the same cycle.
  always_comb begin
    active_s   = (state_r == ST_FETCH) || (state_r == ST_WAIT);
    imem_req_s = 1'b0;
    if (reset && active_s && !overflow_error_warning && !halt && !pc_op && !stall) begin
      imem_req_s = 1'b1;
    end else begin
      imem_req_s = 1'b0;
    end
  end

  // Next-state computation for PC, state and the IF/ID register.
  always_comb begin
    pc_s          = pc_r;
    state_s       = state_r;
    if_instr_s    = if_instr_r;
    if_pc_s       = if_pc_r;
    if_valid_s    = if_valid_r;
    fetch_count_s = fetch_count_r;

    if (overflow_error_warning) begin
      // Error wins from any state, including HALTED.
      state_s    = ST_ERROR;
      if_valid_s = 1'b0;
      if_instr_s = BUBBLE_INSTR;
    end else if (state_r == ST_ERROR) begin
      // Sticky: hold everything, halt is ignored here.
      state_s = ST_ERROR;
    end else if (halt || (state_r == ST_HALTED)) begin
      state_s    = ST_HALTED;
      if_valid_s = 1'b0;
      if_instr_s = BUBBLE_INSTR;
    end else if (pc_op) begin
      // Redirect abandons any outstanding WAIT request; imem_ready is ignored.
      pc_s       = redirect_target(b_jmp, id_pc, branch_offset, jump_field);
      state_s    = ST_FETCH;
      if_valid_s = 1'b0;
      if (if_flush) begin
        if_instr_s = BUBBLE_INSTR;
      end else begin
        if_instr_s = if_instr_r;
      end
    end else if (stall) begin
      // Stall freezes the whole stage, state included.
      state_s = state_r;
    end else if (imem.imem_ready) begin
      pc_s          = pc_r + 16'h0002;
      state_s       = ST_FETCH;
      if_pc_s       = pc_r;
      fetch_count_s = sat_inc(fetch_count_r);
      if (if_flush) begin
        if_instr_s = BUBBLE_INSTR;
        if_valid_s = 1'b0;
      end else begin
        if_instr_s = imem.imem_data;
        if_valid_s = 1'b1;
      end
    end else begin
      // Memory not ready: keep the address, no valid word for ID.
      state_s    = ST_WAIT;
      if_valid_s = 1'b0;
      if (if_flush) begin
        if_instr_s = BUBBLE_INSTR;
      end else begin
        if_instr_s = if_instr_r;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r          <= RESET_PC;
      state_r       <= ST_FETCH;
      if_instr_r    <= BUBBLE_INSTR;
      if_pc_r       <= 16'h0000;
      if_valid_r    <= 1'b0;
      fetch_count_r <= 16'h0000;
    end else begin
      pc_r          <= pc_s;
      state_r       <= state_s;
      if_instr_r    <= if_instr_s;
      if_pc_r       <= if_pc_s;
      if_valid_r    <= if_valid_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign imem.imem_req  = imem_req_s;
  assign imem.imem_addr = pc_r;

  assign if_instr    = if_instr_r;
  assign if_pc       = if_pc_r;
  assign if_valid    = if_valid_r;
  assign fetch_count = fetch_count_r;

  assign state  = state_r;
  assign halted = (state_r == ST_HALTED) || (state_r == ST_ERROR);
  assign error  = (state_r == ST_ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed scenarios followed by randomized cycles, each cycle compared with a
// behavioural model of the fetch rules kept in plain integers.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        pc_op;
  logic        b_jmp;
  logic        if_flush;
  logic        halt;
  logic        ovf;
  logic        stall;
  logic [15:0] id_pc;
  logic [15:0] branch_offset;
  logic [11:0] jump_field;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic        error;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  fetch_unit_if bus();

  fetch_unit #(
    .RESET_PC     (16'h0000),
    .BUBBLE_INSTR (16'hF000)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .pc_op                  (pc_op),
    .b_jmp                  (b_jmp),
    .if_flush               (if_flush),
    .halt                   (halt),
    .overflow_error_warning (ovf),
    .stall                  (stall),
    .id_pc                  (id_pc),
    .branch_offset          (branch_offset),
    .jump_field             (jump_field),
    .imem                   (bus),
    .if_instr               (if_instr),
    .if_pc                  (if_pc),
    .if_valid               (if_valid),
    .halted                 (halted),
    .error                  (error),
    .state                  (state),
    .fetch_count            (fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: state codes 0 FETCH, 1 WAIT, 2 HALTED, 3 ERROR.
  int m_pc    = 0;
  int m_st    = 0;
  int m_instr = 'hF000;
  int m_ifpc  = 0;
  int m_valid = 0;
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_req();
    if (reset === 1'b1 && !ovf && !halt && !pc_op && !stall && m_st < 2) return 1;
    return 0;
  endfunction

  // One clock edge of the fetch rules.
  task automatic model_edge();
    if (reset === 1'b0) begin
      m_pc = 0; m_st = 0; m_instr = 'hF000; m_ifpc = 0; m_valid = 0; m_cnt = 0;
    end else if (ovf) begin
      m_st = 3; m_valid = 0; m_instr = 'hF000;
    end else if (m_st == 3) begin
      m_st = 3;
    end else if (halt || m_st == 2) begin
      m_st = 2; m_valid = 0; m_instr = 'hF000;
    end else if (pc_op) begin
      if (b_jmp) m_pc = (int'(id_pc) + int'(branch_offset)) % 65536;
      else       m_pc = (int'(id_pc) / 8192) * 8192 + int'(jump_field) * 2;
      m_st = 0; m_valid = 0;
      if (if_flush) m_instr = 'hF000;
    end else if (stall) begin
      m_st = m_st;
    end else if (bus.imem_ready) begin
      m_ifpc  = m_pc;
      m_pc    = (m_pc + 2) % 65536;
      m_st    = 0;
      m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_instr = if_flush ? 'hF000 : int'(bus.imem_data);
      m_valid = if_flush ? 0 : 1;
    end else begin
      m_st = 1; m_valid = 0;
      if (if_flush) m_instr = 'hF000;
    end
  endtask

  task automatic check_regs();
    check("if_valid",    {15'd0, if_valid}, 16'(m_valid));
    check("if_instr",    if_instr,          16'(m_instr));
    check("if_pc",       if_pc,             16'(m_ifpc));
    check("fetch_count", fetch_count,       16'(m_cnt));
  endtask

  // Called at posedge+1 with inputs already applied; returns at posedge+1.
  task automatic step();
    #2;
    check("imem_req",  {15'd0, bus.imem_req}, 16'(model_req()));
    check("imem_addr", bus.imem_addr,         16'(m_pc));
    check("state",     {14'd0, state},        16'(m_st));
    check("halted",    {15'd0, halted},       16'(m_st >= 2));
    check("error",     {15'd0, error},        16'(m_st == 3));
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic set_idle();
    reset = 1'b1; pc_op = 1'b0; b_jmp = 1'b0; if_flush = 1'b0; halt = 1'b0;
    ovf = 1'b0; stall = 1'b0; id_pc = 16'h0000; branch_offset = 16'h0000;
    jump_field = 12'h000; bus.imem_ready = 1'b1; bus.imem_data = 16'h1234;
  endtask

  task automatic reset_cycle();
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
    reset = 1'b1;
    #1;
    check("rst_state",  {14'd0, state},        16'h0000);
    check("rst_addr",   bus.imem_addr,         16'h0000);
    check("rst_halted", {15'd0, halted},       16'h0000);
    check("rst_error",  {15'd0, error},        16'h0000);
    check("rst_instr",  if_instr,              16'hF000);
    check("rst_valid",  {15'd0, if_valid},     16'h0000);
    check("rst_count",  fetch_count,           16'h0000);
  endtask

  initial begin
    set_idle();
    @(posedge clk);
    #1;
    reset_cycle();

    // Back-to-back fetches with memory always ready.
    set_idle();
    check("seq_addr0", bus.imem_addr, 16'h0000);
    step();
    check("seq_valid1", {15'd0, if_valid}, 16'h0001);
    check("seq_instr1", if_instr, 16'h1234);
    check("seq_addr1", bus.imem_addr, 16'h0002);
    step();
    check("seq_addr2", bus.imem_addr, 16'h0004);
    step();
    check("seq_count3", fetch_count, 16'h0003);

    // Memory wait at 0004.
    reset_cycle();
    set_idle();
    step();
    step();
    bus.imem_ready = 1'b0;
    step();
    check("wait_state1", {14'd0, state}, 16'h0001);
    check("wait_addr1", bus.imem_addr, 16'h0004);
    check("wait_valid1", {15'd0, if_valid}, 16'h0000);
    step();
    check("wait_state2", {14'd0, state}, 16'h0001);
    check("wait_addr2", bus.imem_addr, 16'h0004);
    bus.imem_ready = 1'b1;
    step();
    check("wait_ifpc", if_pc, 16'h0004);
    check("wait_addr3", bus.imem_addr, 16'h0006);
    check("wait_state3", {14'd0, state}, 16'h0000);

    // Branch with flush, then jump.
    pc_op = 1'b1; b_jmp = 1'b1; if_flush = 1'b1;
    id_pc = 16'h0010; branch_offset = 16'hFFF8;
    step();
    set_idle();
    check("br_addr", bus.imem_addr, 16'h0008);
    check("br_instr", if_instr, 16'hF000);
    check("br_valid", {15'd0, if_valid}, 16'h0000);
    pc_op = 1'b1; b_jmp = 1'b0; id_pc = 16'hE000; jump_field = 12'h123;
    step();
    set_idle();
    check("jmp_addr", bus.imem_addr, 16'hE246);

    // PC wrap at FFFE.
    pc_op = 1'b1; b_jmp = 1'b1; id_pc = 16'h0000; branch_offset = 16'hFFFE;
    step();
    set_idle();
    check("wrap_addr0", bus.imem_addr, 16'hFFFE);
    step();
    check("wrap_ifpc", if_pc, 16'hFFFE);
    check("wrap_addr1", bus.imem_addr, 16'h0000);

    // Halt beats stall, then overflow moves to ERROR, reset recovers.
    halt = 1'b1; stall = 1'b1;
    step();
    set_idle();
    #1;
    check("halt_state", {14'd0, state}, 16'h0002);
    check("halt_req", {15'd0, bus.imem_req}, 16'h0000);
    check("halt_halted", {15'd0, halted}, 16'h0001);
    pc_op = 1'b1; b_jmp = 1'b1; branch_offset = 16'h0040;
    step();
    set_idle();
    step();
    ovf = 1'b1;
    step();
    set_idle();
    #1;
    check("err_state", {14'd0, state}, 16'h0003);
    check("err_error", {15'd0, error}, 16'h0001);
    halt = 1'b1;
    step();
    set_idle();
    reset_cycle();
    step();

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 24) != 0);
      ovf            = ($urandom_range(0, 99) == 0);
      halt           = ($urandom_range(0, 59) == 0);
      pc_op          = ($urandom_range(0, 7) == 0);
      b_jmp          = 1'($urandom_range(0, 1));
      if_flush       = pc_op & 1'($urandom_range(0, 1));
      stall          = ($urandom_range(0, 5) == 0);
      id_pc          = 16'($urandom);
      branch_offset  = 16'($urandom);
      jump_field     = 12'($urandom);
      bus.imem_ready = ($urandom_range(0, 3) != 0);
      bus.imem_data  = 16'($urandom);
      step();
    end

    // Saturation of the fetch counter.
    set_idle();
    reset_cycle();
    for (int i = 0; i < 65540; i++) begin
      bus.imem_data = 16'(i);
      step();
    end
    check("sat_count", fetch_count, 16'hFFFF);
    step();
    check("sat_hold", fetch_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter BUBBLE_INSTR, default 16'hF000, meaning the instruction word injected on flush (A-type, function 0000, no register write).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports pc_op, b_jmp, if_flush, halt, overflow_error_warning  input  1 each  control-unit outputs for the instruction in ID.
REQ-006 SHALL have port stall  input  1  hazard stall; holds fetch.
REQ-007 SHALL have port id_pc  input  16  PC of the instruction currently in ID.
REQ-008 SHALL have port branch_offset  input  16  signed byte offset for taken branch.
REQ-009 SHALL have port jump_field  input  12  jump target field.
REQ-010 SHALL have ports imem_req  output  1, imem_addr  output  16, imem_ready  input  1, imem_data  input  16  instruction-memory handshake.
REQ-011 SHALL have ports if_instr  output  16, if_pc  output  16, if_valid  output  1  IF/ID register.
REQ-012 SHALL have ports halted  output  1, error  output  1, state  output  2, fetch_count  output  16.

Function
REQ-013 SHALL implement states FETCH=2'b00, WAIT=2'b01, HALTED=2'b10, ERROR=2'b11, visible on state.
REQ-014 SHALL apply per-cycle priority: reset > overflow_error_warning > halt > pc_op redirect > stall > normal fetch.
REQ-015 SHALL, in FETCH/WAIT without stall or redirect, drive imem_req=1 and imem_addr=pc.
REQ-016 SHALL, when imem_req=1 and imem_ready=1, load if_instr=imem_data, if_pc=pc, if_valid=1, pc=pc+2 (mod 2^16, FFFE wraps to 0000), enter FETCH.
REQ-017 SHALL, when imem_req=1 and imem_ready=0, enter/stay in WAIT with imem_addr held unchanged; if_valid=0 next cycle.
REQ-018 SHALL, when pc_op=1 and b_jmp=1, load pc=id_pc+branch_offset (16-bit wrap).
REQ-019 SHALL, when pc_op=1 and b_jmp=0, load pc={id_pc[15:13], jump_field, 1'b0}.
REQ-020 SHALL, on redirect cycle, drive imem_req=0, ignore imem_ready, abandon any WAIT request, enter FETCH.
REQ-021 SHALL, when if_flush=1 (with or without redirect), load if_instr=BUBBLE_INSTR, if_valid=0 next cycle.
REQ-022 SHALL, when stall=1 (no higher-priority event), drive imem_req=0 and hold pc, if_instr, if_pc, if_valid, state.
REQ-023 SHALL, when halt=1, enter HALTED: imem_req=0, if_valid=0, if_instr=BUBBLE_INSTR, halted=1, pc held.
REQ-024 SHALL, when overflow_error_warning=1 in any state, enter ERROR: halted=1, error=1, imem_req=0, if_valid=0, if_instr=BUBBLE_INSTR.
REQ-025 SHALL keep HALTED and ERROR sticky until reset; halt ignored in ERROR; overflow moves HALTED to ERROR.
REQ-026 SHALL increment fetch_count on every accepted fetch (REQ-016), saturating at 16'hFFFF.
REQ-027 SHALL have imem_req, halted, error, state combinational from current state and inputs only as stated; if_* and fetch_count registered.

Reset
REQ-028 SHALL, on clk edge with reset=0: pc=RESET_PC, state=FETCH, if_instr=BUBBLE_INSTR, if_pc=16'h0000, if_valid=0, halted=0, error=0, fetch_count=0, overriding all other inputs.
REQ-029 SHALL, on reset mid-WAIT or HALTED/ERROR, discard the outstanding request and restart fetch at RESET_PC next cycle.

Verification
REQ-030 SHALL cover: reset, imem_ready=1 constant, data 16'h1234 -> imem_addr 0000,0002,0004; if_valid=1 from cycle 2; fetch_count=3 after 3 fetches.
REQ-031 SHALL cover: imem_ready=0 two cycles at addr 0004 -> state=WAIT, imem_addr stays 0004, if_valid=0; ready=1 -> if_pc=0004, pc=0006.
REQ-032 SHALL cover: id_pc=0010, branch_offset=16'hFFF8, pc_op=1, b_jmp=1, if_flush=1 -> pc=0008, if_instr=F000, if_valid=0; jump_field=12'h123 with id_pc=E000 -> pc=E246.
REQ-033 SHALL cover: halt=1 with stall=1 same cycle -> HALTED, imem_req=0, halted=1; later overflow_error_warning=1 -> ERROR, error=1; reset=0 -> FETCH at 0000.
REQ-034 SHALL cover: pc=FFFE fetch -> pc=0000; fetch_count preset path to FFFF stays FFFF on further fetches.
